// File: rtl/am_search_if.sv
// am_search_if: query, result and associative-memory read bus of the
// nearest-class search engine. slave = engine side, master = environment.
interface am_search_if #(
    parameter int HV_LENGTH = 2048,
    parameter int ADDR_W    = 13,
    parameter int N_CLASSES = 32,
    parameter int CLS_W     = $clog2(N_CLASSES),
    parameter int DIST_W    = $clog2(HV_LENGTH + 1)
);
    logic                 query_valid_i;
    logic                 query_ready_o;
    logic [HV_LENGTH-1:0] query_hv_i;
    logic [CLS_W:0]       num_classes_i;
    logic [ADDR_W-1:0]    am_addr_o;
    logic                 am_ren_o;
    logic                 am_wen_o;
    logic [HV_LENGTH-1:0] am_rdata_i;
    logic                 result_valid_o;
    logic                 result_ready_i;
    logic [CLS_W-1:0]     result_class_o;
    logic [DIST_W-1:0]    result_dist_o;

    modport slave (
        input  query_valid_i, query_hv_i, num_classes_i,
        input  am_rdata_i, result_ready_i,
        output query_ready_o, am_addr_o, am_ren_o, am_wen_o,
        output result_valid_o, result_class_o, result_dist_o
    );

    modport master (
        output query_valid_i, query_hv_i, num_classes_i,
        output am_rdata_i, result_ready_i,
        input  query_ready_o, am_addr_o, am_ren_o, am_wen_o,
        input  result_valid_o, result_class_o, result_dist_o
    );
endinterface

// File: rtl/am_search_engine.sv
// am_search_engine: streams AM rows one per cycle, computes the Hamming
// distance to the latched query and returns the nearest class.
module am_search_engine #(
    parameter int HV_LENGTH = 2048,
    parameter int ADDR_W    = 13,
    parameter int N_CLASSES = 32,
    parameter int CLS_W     = $clog2(N_CLASSES),
    parameter int DIST_W    = $clog2(HV_LENGTH + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    am_search_if.slave bus,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [CLS_W:0] ONE   = (CLS_W+1)'(1);
    localparam logic [CLS_W:0] N_MAX = (CLS_W+1)'(N_CLASSES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_last_issue;
    logic [CLS_W:0]       w_n_clamped;

    logic [HV_LENGTH-1:0] r_query;
    logic [CLS_W:0]       r_n;
    logic [CLS_W:0]       r_issue_idx;

    logic                 r_valid_d1;
    logic                 r_last_d1;
    logic [CLS_W-1:0]     r_idx_d1;
    logic                 r_valid_d2;
    logic                 r_last_d2;
    logic [CLS_W-1:0]     r_idx_d2;
    logic [DIST_W-1:0]    r_dist_q;

    logic                 r_first;
    logic [CLS_W-1:0]     r_best_idx;
    logic [DIST_W-1:0]    r_best_dist;

    function automatic logic [DIST_W-1:0] popcount(input logic [HV_LENGTH-1:0] v);
        logic [DIST_W-1:0] c;
        c = '0;
        for (int i = 0; i < HV_LENGTH; i++) begin
            c = c + DIST_W'(v[i]);
        end
        return c;
    endfunction

    // Zero or oversize row counts fall back to a full scan.
    assign w_n_clamped = (bus.num_classes_i == '0 || bus.num_classes_i > N_MAX)
                       ? N_MAX : bus.num_classes_i;

    assign w_last_issue = (r_issue_idx == r_n - ONE);

    // Next-state decode; DRAIN waits for the last row's compare.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.query_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_valid_d2 && r_last_d2) w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.result_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Query latch and read-issue counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_query     <= '0;
            r_n         <= '0;
            r_issue_idx <= '0;
        end else if (w_accept) begin
            r_query     <= bus.query_hv_i;
            r_n         <= w_n_clamped;
            r_issue_idx <= '0;
        end else if (r_state == SCAN) begin
            r_issue_idx <= r_issue_idx + ONE;
        end
    end

    // Read-issue stage and distance stage; rdata arrives one cycle after issue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_d1 <= 1'b0;
            r_last_d1  <= 1'b0;
            r_idx_d1   <= '0;
            r_valid_d2 <= 1'b0;
            r_last_d2  <= 1'b0;
            r_idx_d2   <= '0;
            r_dist_q   <= '0;
        end else begin
            r_valid_d1 <= (r_state == SCAN);
            r_last_d1  <= (r_state == SCAN) && w_last_issue;
            r_idx_d1   <= r_issue_idx[CLS_W-1:0];
            r_valid_d2 <= r_valid_d1;
            if (r_valid_d1) begin
                r_dist_q  <= popcount(r_query ^ bus.am_rdata_i);
                r_idx_d2  <= r_idx_d1;
                r_last_d2 <= r_last_d1;
            end
        end
    end

    // Running minimum; strict compare keeps the lower index on ties.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_first     <= 1'b1;
            r_best_idx  <= '0;
            r_best_dist <= '0;
        end else if (w_accept) begin
            r_first <= 1'b1;
        end else if (r_valid_d2) begin
            r_first <= 1'b0;
            if (r_first || r_dist_q < r_best_dist) begin
                r_best_idx  <= r_idx_d2;
                r_best_dist <= r_dist_q;
            end
        end
    end

    assign bus.query_ready_o  = (r_state == IDLE);
    assign bus.am_ren_o       = (r_state == SCAN);
    assign bus.am_wen_o       = 1'b0;
    assign bus.am_addr_o      = (r_state == SCAN)
                              ? (ADDR_W'(r_issue_idx) << 8) : '0;
    assign bus.result_valid_o = (r_state == DONE);
    assign bus.result_class_o = r_best_idx;
    assign bus.result_dist_o  = r_best_dist;
    assign busy_o             = (r_state != IDLE);

endmodule

// File: tb/tb_am_search_engine.sv
// tb_am_search_engine: directed tests of the nearest-class search engine
// against a one-cycle-latency associative-memory model.
module tb_am_search_engine;
    localparam int HV     = 2048;
    localparam int ADDR_W = 13;
    localparam int NCLS   = 32;
    localparam int CLS_W  = 5;
    localparam int DIST_W = 12;

    logic clk;
    logic rst;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    logic [HV-1:0] mem [NCLS];

    am_search_if #(.HV_LENGTH(HV), .ADDR_W(ADDR_W), .N_CLASSES(NCLS)) bus ();

    am_search_engine #(.HV_LENGTH(HV), .ADDR_W(ADDR_W), .N_CLASSES(NCLS)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.am_ren_o) bus.am_rdata_i <= mem[bus.am_addr_o[ADDR_W-1:8]];
    end

    function automatic logic [HV-1:0] ones(input int cnt, input int off);
        logic [HV-1:0] r;
        r = '0;
        for (int i = 0; i < cnt; i++) r[off+i] = 1'b1;
        return r;
    endfunction

    function automatic logic [HV-1:0] rand_hv();
        logic [HV-1:0] r;
        for (int w = 0; w < HV/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_query(input logic [HV-1:0] hv, input logic [CLS_W:0] num,
                             input int n, input logic [CLS_W-1:0] ecls,
                             input logic [DIST_W-1:0] edist, input int hold,
                             input string tag);
        int bad;
        int c;
        int extra;
        @(negedge clk);
        checks++;
        if (bus.query_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s ready: got %b want 1", tag, bus.query_ready_o);
        end
        bus.query_valid_i = 1'b1;
        bus.query_hv_i    = hv;
        bus.num_classes_i = num;
        @(posedge clk);
        #1;
        bus.query_valid_i = 1'b0;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.am_ren_o !== 1'b1 || bus.am_wen_o !== 1'b0 ||
                bus.am_addr_o !== ADDR_W'(k*256)) begin
                bad++;
                if (bad == 1)
                    $display("FAIL %s read k=%0d: got ren=%b wen=%b addr=%h want ren=1 wen=0 addr=%h",
                             tag, k, bus.am_ren_o, bus.am_wen_o, bus.am_addr_o, ADDR_W'(k*256));
            end
        end
        checks++;
        if (bad != 0) failures++;
        c = n;
        extra = 0;
        while (c < n + 40) begin
            @(negedge clk);
            c++;
            if (bus.result_valid_o === 1'b1) break;
            if (bus.am_ren_o !== 1'b0) extra++;
        end
        checks++;
        if (c != n + 3) begin
            failures++;
            $display("FAIL %s latency: got cycle %0d want %0d", tag, c, n + 3);
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL %s drain_reads: got %0d want 0", tag, extra);
        end
        checks++;
        if (bus.result_class_o !== ecls || bus.result_dist_o !== edist) begin
            failures++;
            $display("FAIL %s result: got class=%0d dist=%0d want class=%0d dist=%0d",
                     tag, bus.result_class_o, bus.result_dist_o, ecls, edist);
        end
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            bus.query_valid_i = h[0];
            bus.query_hv_i    = ~hv;
            @(negedge clk);
            if (bus.result_valid_o !== 1'b1 || bus.result_class_o !== ecls ||
                bus.result_dist_o !== edist || bus.query_ready_o !== 1'b0 ||
                busy !== 1'b1 || bus.am_ren_o !== 1'b0) begin
                bad++;
                if (bad == 1)
                    $display("FAIL %s hold h=%0d: got v=%b cls=%0d dist=%0d rdy=%b ren=%b want v=1 cls=%0d dist=%0d rdy=0 ren=0",
                             tag, h, bus.result_valid_o, bus.result_class_o, bus.result_dist_o,
                             bus.query_ready_o, bus.am_ren_o, ecls, edist);
            end
        end
        bus.query_valid_i = 1'b0;
        if (hold > 0) begin
            checks++;
            if (bad != 0) failures++;
        end
        bus.result_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.result_valid_o !== 1'b0 || bus.query_ready_o !== 1'b1 ||
            busy !== 1'b0 || bus.am_ren_o !== 1'b0) begin
            failures++;
            $display("FAIL %s release: got v=%b rdy=%b busy=%b ren=%b want 0 1 0 0",
                     tag, bus.result_valid_o, bus.query_ready_o, busy, bus.am_ren_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.query_ready_o !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: got rdy=%b busy=%b want 1 0", bus.query_ready_o, busy);
        end
        checks++;
        if (bus.am_ren_o !== 1'b0 || bus.am_wen_o !== 1'b0 || bus.am_addr_o !== '0) begin
            failures++;
            $display("FAIL reset_mem: got ren=%b wen=%b addr=%h want 0 0 0",
                     bus.am_ren_o, bus.am_wen_o, bus.am_addr_o);
        end
        checks++;
        if (bus.result_valid_o !== 1'b0 || bus.result_class_o !== '0 ||
            bus.result_dist_o !== '0) begin
            failures++;
            $display("FAIL reset_res: got v=%b cls=%0d dist=%0d want 0 0 0",
                     bus.result_valid_o, bus.result_class_o, bus.result_dist_o);
        end
    endtask

    task automatic load_exact(output logic [HV-1:0] q);
        q = rand_hv();
        for (int k = 0; k < NCLS; k++) mem[k] = q ^ rand_hv();
        mem[5] = q;
    endtask

    task automatic test_exact_match();
        logic [HV-1:0] q;
        load_exact(q);
        run_query(q, 6'd32, 32, 5'd5, 12'd0, 0, "exact");
    endtask

    task automatic test_max_distance();
        logic [HV-1:0] q;
        q = '1;
        for (int k = 0; k < NCLS; k++) mem[k] = '0;
        mem[31] = ones(1, 100);
        run_query(q, 6'd32, 32, 5'd31, 12'd2047, 0, "maxdist_row31");
        mem[31] = '0;
        run_query(q, 6'd40, 32, 5'd0, 12'd2048, 0, "maxdist_allzero");
    endtask

    task automatic test_tie();
        logic [HV-1:0] q;
        q = '0;
        for (int k = 0; k < NCLS; k++) mem[k] = ones(20 + k, 0);
        mem[3] = ones(10, 0);
        mem[7] = ones(10, 100);
        run_query(q, 6'd0, 32, 5'd3, 12'd10, 0, "tie");
    endtask

    task automatic test_partial_backpressure();
        logic [HV-1:0] q;
        q = rand_hv();
        for (int k = 0; k < NCLS; k++) mem[k] = q ^ ones(50, 0);
        mem[0] = q ^ ones(30, 0);
        mem[1] = q ^ ones(25, 5);
        mem[2] = q ^ ones(40, 0);
        mem[3] = q ^ ones(25, 500);
        mem[9] = q;
        run_query(q, 6'd4, 4, 5'd1, 12'd25, 10, "partial");
    endtask

    task automatic test_single_row();
        logic [HV-1:0] q;
        q = rand_hv();
        mem[0] = q ^ ones(7, 3);
        mem[1] = q;
        run_query(q, 6'd1, 1, 5'd0, 12'd7, 0, "single");
    endtask

    task automatic test_reset_mid_scan();
        logic [HV-1:0] q;
        int bad;
        load_exact(q);
        @(negedge clk);
        bus.query_valid_i = 1'b1;
        bus.query_hv_i    = q;
        bus.num_classes_i = 6'd32;
        @(posedge clk);
        #1;
        bus.query_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.am_ren_o !== 1'b1 || bus.am_addr_o !== 13'h900) begin
            failures++;
            $display("FAIL midrst_pre: got ren=%b addr=%h want 1 0900", bus.am_ren_o, bus.am_addr_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.am_ren_o !== 1'b0 || busy !== 1'b0 || bus.query_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_abort: got ren=%b busy=%b rdy=%b want 0 0 1",
                     bus.am_ren_o, busy, bus.query_ready_o);
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid_o !== 1'b0 || bus.am_ren_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got %0d active cycles want 0", bad);
        end
        run_query(q, 6'd32, 32, 5'd5, 12'd0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [HV-1:0] q;
        q = '0;
        for (int k = 0; k < NCLS; k++) mem[k] = ones(60 - k, 0);
        run_query(q, 6'd8, 8, 5'd7, 12'd53, 0, "b2b_a");
        run_query(q, 6'd3, 3, 5'd2, 12'd58, 0, "b2b_b");
    endtask

    initial begin
        rst                = 1'b1;
        bus.query_valid_i  = 1'b0;
        bus.query_hv_i     = '0;
        bus.num_classes_i  = '0;
        bus.result_ready_i = 1'b0;
        for (int k = 0; k < NCLS; k++) mem[k] = '0;
        test_reset();
        test_exact_match();
        test_max_distance();
        test_tie();
        test_partial_backpressure();
        test_single_row();
        test_reset_mid_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/am_search_engine.md
# am_search_engine

Query-side consumer of the associative memory. It accepts one query hypervector, then streams class hypervectors out of the associative memory SRAM one row per cycle. For each row it computes the Hamming distance to the query and keeps a running minimum. It returns the index and distance of the closest class, which is the classification stage of the HDC accelerator sitting directly downstream of the associative memory.

## Interface
Parameters:
- HV_LENGTH, 2048, hypervector width in bits; must be a multiple of 64.
- ADDR_W, 13, associative-memory byte address width. Row k sits at byte address k*256, i.e. row index in am_addr_o[ADDR_W-1:8].
- N_CLASSES, 32, maximum number of stored classes; must not exceed 2^(ADDR_W-8).
- CLS_W, $clog2(N_CLASSES), class index width.
- DIST_W, $clog2(HV_LENGTH+1), distance width.

Ports:
- clk_i  in  1  clock; single clock domain. Reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- query_valid_i  in  1  query offered.
- query_ready_o  out  1  engine idle and able to accept a query.
- query_hv_i  in  HV_LENGTH  query hypervector; sampled on handshake.
- num_classes_i  in  CLS_W+1  number of rows to scan; sampled on handshake. 0 or values above N_CLASSES are clamped to N_CLASSES.
- am_addr_o  out  ADDR_W  byte address to the associative memory.
- am_ren_o  out  1  read strobe.
- am_wen_o  out  1  write strobe; constant 0.
- am_rdata_i  in  HV_LENGTH  memory read data; valid one cycle after the read is issued.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  result consumed.
- result_class_o  out  CLS_W  index of the nearest class.
- result_dist_o  out  DIST_W  Hamming distance of the nearest class.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - query_ready_o = 1.
  - On query_valid_i & query_ready_o: latch query_hv_i, latch n = clamp(num_classes_i), clear issue_idx, go to SCAN.
- SCAN:
  - am_ren_o = 1 and am_addr_o = issue_idx << 8, one read per cycle.
  - issue_idx increments each cycle.
  - After issuing issue_idx = n-1, go to DRAIN.
- Pipeline:
  - Stage 1: the issue registers valid_d1 and idx_d1.
  - Stage 2: when valid_d1 is set, dist_q <= popcount(query ^ am_rdata_i), with idx_d2 and valid_d2.
  - Stage 3: when valid_d2 is set, compare. For the first compare of a query, or when dist_q < best_dist (strict), best_dist <= dist_q and best_idx <= idx_d2.
  - Ties keep the lower index.
- DRAIN: when the compare of the last row completes, go to DONE.
- DONE:
  - result_valid_o = 1, with result_class_o = best_idx and result_dist_o = best_dist held stable.
  - On result_ready_i, go to IDLE.
- Outside SCAN, am_ren_o = 0 and am_wen_o = 0, so the memory stays deselected.
- Arithmetic: popcount is an unsigned sum over HV_LENGTH XOR bits. The maximum value HV_LENGTH fits DIST_W without overflow.

## Timing
- Handshake occurs in cycle 0.
- Read for row k is issued in cycle 1+k.
- am_rdata_i for row k is sampled at the end of cycle 2+k.
- best is updated at the end of cycle 3+k.
- result_valid_o rises in cycle n+3. For n=32, that is cycle 35.
- A new query is accepted no earlier than the cycle after the result handshake, because query_ready_o is 0 in DONE.
- query_valid_i while busy is ignored; the engine neither stores nor acknowledges it.
- result_valid_o stays high with stable data under backpressure for any number of cycles.
- Reset values: query_ready_o=1 once rst_i is low; am_ren_o=0, am_wen_o=0, am_addr_o=0, result_valid_o=0, result_class_o=0, result_dist_o=0, busy_o=0.
- Reset mid-operation, in any state:
  - Next cycle is IDLE; all pipeline valids clear.
  - am_ren_o drops in the cycle after rst_i is sampled.
  - No result is produced for the aborted query.
- n=1: a single read in cycle 1, result in cycle 4.

## Test plan
- Reset: hold rst_i 3 cycles, then release → query_ready_o=1, busy_o=0, am_ren_o=0, result_valid_o=0, all data outputs 0.
- Full scan, exact match: N_CLASSES=32, num_classes_i=32, row 5 = query, other rows random (distance ≥ 900) → addresses 0x000..0x1F00 in steps of 0x100 on cycles 1..32; result_valid_o in cycle 35 with class 5, dist 0.
- Max distance: query all ones, every row all zeros except row 31 with 1 set bit → class 31, dist 2047; with all rows zero → class 0, dist 2048.
- Tie: rows 3 and 7 both at distance 10, all others at ≥ 20 → class 3, dist 10.
- Partial scan with backpressure: num_classes_i=4, best row at index 9 → only 0x000–0x300 read; result in cycle 7 excludes row 9. Hold result_ready_i=0 for 10 cycles while pulsing query_valid_i → outputs stable, no accept.
- Reset mid-scan: assert rst_i in cycle 10 of a 32-row scan → am_ren_o=0 from cycle 11, no result. A following query completes correctly with full latency.
